ram_arbiter: RTL

Round-robin arbiter that lets up to CORES processor cores share one single-port RAM instance. It is the requesting side of the RAM interface: it drives write-enable, address and write data, and samples the RAM's negedge-registered read data. Each core sees a simple req/ack handshake. The block sits between the core array and the shared data/instruction memory.

---
 rtl/ram_arb_pkg.sv | 9 +
 rtl/ram_arbiter_rr_select.sv | 29 ++
 rtl/ram_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the round-robin RAM arbiter.
// Every access takes IDLE -> ACCESS -> RESP: the ack arrives ACCESS_LAT cycles after the winning request is sampled.
package ram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam int ACCESS_LAT = 2;

endpackage

// File: rtl/ram_arbiter_rr_select.sv
// Combinational round-robin picker.
// Returns the first requester found by searching from ptr_i upward, modulo CORES.
module rr_select #(
  parameter int CORES = 4,
  localparam int PW = (CORES > 1) ? $clog2(CORES) : 1
) (
  input  logic [CORES-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [PW-1:0]    winner_o,
  output logic             valid_o
);

  logic [PW-1:0] idx;

  // The loop runs from the farthest offset down to the nearest one, so the requester closest to ptr_i wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_i) + i) % CORES);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Lets CORES cores share one single-port RAM through a round-robin scheduler.
// Each core uses a req/ack handshake, and every access takes three cycles.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int CORES      = 4,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                              clk,
  input  logic                              rstN,
  input  logic [CORES-1:0]                  req,
  input  logic [CORES-1:0]                  we,
  input  logic [CORES-1:0][ADDR_WIDTH-1:0]  addr,
  input  logic [CORES-1:0][WIDTH-1:0]       wdata,
  output logic [CORES-1:0]                  ack,
  output logic [WIDTH-1:0]                  rdata,
  output logic                              busy,
  output logic                              ram_wrEn,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic [WIDTH-1:0]                  ram_dataIn,
  input  logic [WIDTH-1:0]                  ram_dataOut
);

  localparam int PW = $clog2(CORES);

  state_e                 state_q, state_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          winner_q, winner_d;
  logic                   we_q, we_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic [PW-1:0]          grantIdx;
  logic                   grantValid;

  rr_select #(.CORES(CORES)) uSelect (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (grantIdx),
    .valid_o  (grantValid)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grantValid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Requests are only sampled in IDLE.
  // rdata takes the RAM's negedge read, which still holds the pre-write word, at the edge that ends ACCESS.
  always_comb begin
    ptr_d    = ptr_q;
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    if (state_q == IDLE && grantValid) begin
      winner_d = grantIdx;
      ptr_d    = (grantIdx == PW'(CORES - 1)) ? '0 : grantIdx + PW'(1);
      we_d     = we[grantIdx];
      addr_d   = addr[grantIdx];
      wdata_d  = wdata[grantIdx];
    end
    if (state_q == ACCESS) rdata_d = ram_dataOut;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr_q    <= '0;
      winner_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // ram_wrEn is decoded from state, so an asynchronous reset pulls it low at once.
  always_comb begin
    ack      = '0;
    busy     = 1'b0;
    ram_wrEn = 1'b0;
    case (state_q)
      ACCESS: begin
        busy     = 1'b1;
        ram_wrEn = we_q;
      end
      RESP: begin
        busy          = 1'b1;
        ack[winner_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_addr   = addr_q;
  assign ram_dataIn = wdata_q;
  assign rdata      = rdata_q;

endmodule
